// File: rtl/pp_combiner_78.sv
// ============================================================================
// pp_combiner_78 : shifts and sums the twelve 78x78 limb partial products into
//                  the 156-bit product over a 2-stage valid/ready pipeline.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pp_combiner_78 #(
  parameter int RADIX  = 78,
  parameter int A_LIMB = 26,
  parameter int B_LIMB = 20,
  parameter int PP_W   = 46,
  parameter int ROW_W  = 106
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PP_W-1:0]       pp_0,
  input  logic [PP_W-1:0]       pp_1,
  input  logic [PP_W-1:0]       pp_2,
  input  logic [PP_W-1:0]       pp_3,
  input  logic [PP_W-1:0]       pp_4,
  input  logic [PP_W-1:0]       pp_5,
  input  logic [PP_W-1:0]       pp_6,
  input  logic [PP_W-1:0]       pp_7,
  input  logic [PP_W-1:0]       pp_8,
  input  logic [PP_W-1:0]       pp_9,
  input  logic [PP_W-1:0]       pp_10,
  input  logic [PP_W-1:0]       pp_11,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*RADIX-1:0]    product
);

  localparam int PROD_W = 2 * RADIX;

  logic [PP_W-1:0]   pp [12];
  logic              en;
  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic [ROW_W-1:0]  row_q [3];
  logic [ROW_W-1:0]  row_d [3];
  logic [PROD_W-1:0] product_q, product_d;

  assign pp[0]  = pp_0;
  assign pp[1]  = pp_1;
  assign pp[2]  = pp_2;
  assign pp[3]  = pp_3;
  assign pp[4]  = pp_4;
  assign pp[5]  = pp_5;
  assign pp[6]  = pp_6;
  assign pp[7]  = pp_7;
  assign pp[8]  = pp_8;
  assign pp[9]  = pp_9;
  assign pp[10] = pp_10;
  assign pp[11] = pp_11;

  // One a-limb row: the four b-limb products at column offsets 0/20/40/60.
  function automatic logic [ROW_W-1:0] row_sum(
    input logic [PP_W-1:0] p0,
    input logic [PP_W-1:0] p1,
    input logic [PP_W-1:0] p2,
    input logic [PP_W-1:0] p3
  );
    row_sum = ROW_W'(p0)
            + (ROW_W'(p1) << B_LIMB)
            + (ROW_W'(p2) << (2 * B_LIMB))
            + (ROW_W'(p3) << (3 * B_LIMB));
  endfunction

  // Single global stall: everything advances only when stage 2 can move.
  assign en        = !v2_q || out_ready;
  assign in_ready  = en && rst_n;
  assign out_valid = v2_q;
  assign product   = product_q;

  always_comb begin
    v1_d      = v1_q;
    v2_d      = v2_q;
    product_d = product_q;
    for (int i = 0; i < 3; i++) begin
      row_d[i] = row_q[i];
    end
    if (en) begin
      v1_d = in_valid;
      v2_d = v1_q;
      if (in_valid) begin
        for (int i = 0; i < 3; i++) begin
          row_d[i] = row_sum(pp[4*i], pp[4*i+1], pp[4*i+2], pp[4*i+3]);
        end
      end
      if (v1_q) begin
        product_d = PROD_W'(row_q[0])
                  + (PROD_W'(row_q[1]) << A_LIMB)
                  + (PROD_W'(row_q[2]) << (2 * A_LIMB));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      product_q <= '0;
      for (int i = 0; i < 3; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      product_q <= product_d;
      for (int i = 0; i < 3; i++) begin
        row_q[i] <= row_d[i];
      end
    end
  end

endmodule

`default_nettype wire
